rtos_readylist: RTL and testbench

RTOS_READYLIST -- requirements
Module: rtos_readylist

---
 rtl/rtos_pkg.sv | 53 +++++
 rtl/rtos_tickgen.sv | 23 ++
 rtl/rtos_readylist.sv | 129 ++++++++++++
 tb/tb_rtos_readylist.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtos_pkg.sv
// Shared encodings, widths and the per-slot scan step for the ready-list scheduler.
package rtos_pkg;

  localparam int SLOT_W = 4;
  localparam int PRI_W  = 6;
  localparam int PTR_W  = 8;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_READY  = 2'b01,
    OP_BLOCK  = 2'b10,
    OP_SETPRI = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

  typedef struct packed {
    logic              found;
    logic              nx_vld;
    logic [PRI_W-1:0]  pri;
    logic [SLOT_W-1:0] hp;
    logic [SLOT_W-1:0] nx;
  } scan_acc_t;

  // nx mirrors hp until a same-priority slot above rr is seen, so it is
  // always the round-robin successor (with wrap) once the scan completes.
  function automatic scan_acc_t scan_step(input scan_acc_t         a,
                                          input logic              rdy,
                                          input logic [PRI_W-1:0]  pri,
                                          input logic [SLOT_W-1:0] idx,
                                          input logic [SLOT_W-1:0] rr);
    scan_acc_t n;
    n = a;
    if (rdy) begin
      if (!a.found || pri > a.pri) begin
        n.found  = 1'b1;
        n.pri    = pri;
        n.hp     = idx;
        n.nx     = idx;
        n.nx_vld = (idx > rr);
      end else if (pri == a.pri && !a.nx_vld && idx > rr) begin
        n.nx     = idx;
        n.nx_vld = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rtos_tickgen.sv
// Free-running system tick divider: one-cycle pulse every TICK_DIV clocks.
module rtos_tickgen #(
  parameter int TICK_DIV = 1000
) (
  input  logic aclk,
  input  logic aresetn,
  output logic tick_out
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)            r_cnt <= '0;
    else if (r_cnt == TERM)  r_cnt <= '0;
    else                     r_cnt <= r_cnt + CW'(1);
  end

  assign tick_out = (r_cnt == TERM);

endmodule

// File: rtl/rtos_readylist.sv
// RTOS ready list: slot table plus a sequential one-slot-per-cycle scan that
// publishes the highest ready priority, its first slot and the round-robin successor.
module rtos_readylist
  import rtos_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int TICK_DIV  = 1000
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_slot,
  input  logic [5:0] cmd_pri,
  output logic       tick_out,
  output logic [5:0] highpriority_out,
  output logic [7:0] ptr_hpritask_out,
  output logic [7:0] ptr_nexttask_out,
  output logic       any_ready_out
);

  localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(NUM_SLOTS - 1);

  logic                              w_tick;
  logic                              w_accept;
  scan_acc_t                         w_acc_nxt;

  logic [NUM_SLOTS-1:0]              r_rdy;
  logic [NUM_SLOTS-1:0][PRI_W-1:0]   r_pri;
  state_e                            r_state;
  logic                              r_cmd_ready;
  logic                              r_tick_pend;
  logic [SLOT_W-1:0]                 r_rr;
  logic [SLOT_W-1:0]                 r_idx;
  scan_acc_t                         r_acc;
  logic [PRI_W-1:0]                  r_hpri;
  logic [SLOT_W-1:0]                 r_hp;
  logic [SLOT_W-1:0]                 r_nx;
  logic                              r_any;

  rtos_tickgen #(.TICK_DIV(TICK_DIV)) u_tickgen (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .tick_out (w_tick)
  );

  assign w_accept  = cmd_valid & r_cmd_ready;
  assign w_acc_nxt = scan_step(r_acc, r_rdy[r_idx], r_pri[r_idx], r_idx, r_rr);

  // Slot table: only written by an accepted command, i.e. only while idle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdy <= '0;
      r_pri <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cmd_slot == SLOT_W'(i)) begin
          case (cmd_op_e'(cmd_op))
            OP_READY: begin
              r_rdy[i] <= 1'b1;
              r_pri[i] <= cmd_pri;
            end
            OP_BLOCK:  r_rdy[i] <= 1'b0;
            OP_SETPRI: r_pri[i] <= cmd_pri;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_tick_pend <= 1'b0;
      r_rr        <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_hpri      <= '0;
      r_hp        <= '0;
      r_nx        <= '0;
      r_any       <= 1'b0;
    end else begin
      // A tick in any state is remembered; repeated ticks merge into one flag.
      if (w_tick) begin
        r_rr        <= r_nx;
        r_tick_pend <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          r_acc <= '0;
          if (w_accept || r_tick_pend) begin
            r_state     <= ST_SCAN;
            r_cmd_ready <= 1'b0;
            if (!w_tick) r_tick_pend <= 1'b0;
          end
        end
        ST_SCAN: begin
          r_acc <= w_acc_nxt;
          r_idx <= r_idx + SLOT_W'(1);
          if (r_idx == LAST_IDX) r_state <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          r_hpri      <= r_acc.pri;
          r_hp        <= r_acc.hp;
          r_nx        <= r_acc.nx;
          r_any       <= r_acc.found;
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready        = r_cmd_ready;
  assign tick_out         = w_tick;
  assign highpriority_out = r_hpri;
  assign ptr_hpritask_out = {{(PTR_W-SLOT_W){1'b0}}, r_hp};
  assign ptr_nexttask_out = {{(PTR_W-SLOT_W){1'b0}}, r_nx};
  assign any_ready_out    = r_any;

endmodule

// File: tb/tb_rtos_readylist.sv
// Bench for rtos_readylist: directed vector table, tick/reset corner sequences
// and randomized commands against a slot-table reference model.
module tb_rtos_readylist;
  import rtos_pkg::*;

  localparam int TD = 400;
  localparam int NS = 16;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_slot = 4'd0;
  logic [5:0] cmd_pri = 6'd0;
  logic       tick_out;
  logic [5:0] highpriority_out;
  logic [7:0] ptr_hpritask_out;
  logic [7:0] ptr_nexttask_out;
  logic       any_ready_out;

  rtos_readylist #(.NUM_SLOTS(NS), .TICK_DIV(TD)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_slot         (cmd_slot),
    .cmd_pri          (cmd_pri),
    .tick_out         (tick_out),
    .highpriority_out (highpriority_out),
    .ptr_hpritask_out (ptr_hpritask_out),
    .ptr_nexttask_out (ptr_nexttask_out),
    .any_ready_out    (any_ready_out)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc;
  bit tchk_en = 1'b0;

  // Edges since reset release; the tick phase follows from this alone.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn && tchk_en) chk("tick_out", int'(tick_out), int'(cyc % TD == TD - 1));
  end

  // ---------------- reference model ----------------
  typedef struct { int hpri; int hp; int nx; int any; } res_t;
  bit m_rdy[NS];
  int m_pri[NS];
  int m_rr;

  function automatic res_t model_eval();
    res_t r;
    int best;
    r = '{0, 0, 0, 0};
    best = -1;
    for (int i = 0; i < NS; i++) if (m_rdy[i] && m_pri[i] > best) best = m_pri[i];
    if (best < 0) return r;
    r.any = 1;
    r.hpri = best;
    r.hp = -1;
    r.nx = -1;
    for (int i = 0; i < NS; i++) begin
      if (m_rdy[i] && m_pri[i] == best) begin
        if (r.hp < 0) r.hp = i;
        if (r.nx < 0 && i > m_rr) r.nx = i;
      end
    end
    if (r.nx < 0) r.nx = r.hp;
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_rdy[i] = 1'b0;
      m_pri[i] = 0;
    end
    m_rr = 0;
  endtask

  task automatic m_apply(input logic [1:0] op, input int slot, input int pri);
    case (op)
      2'b01: begin m_rdy[slot] = 1'b1; m_pri[slot] = pri; end
      2'b10: m_rdy[slot] = 1'b0;
      2'b11: m_pri[slot] = pri;
      default: ;
    endcase
  endtask

  task automatic m_tick();
    res_t r;
    r = model_eval();
    m_rr = r.nx;
  endtask

  // ---------------- helpers ----------------
  task automatic clk(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    @(negedge aclk);
    while (cyc % TD != p && n < 2 * TD) begin
      @(negedge aclk);
      n++;
    end
    if (cyc % TD != p) chk("phase_wait_timeout", cyc % TD, p);
  endtask

  task automatic send(input logic [1:0] op, input int slot, input int pri);
    int n;
    n = 0;
    @(negedge aclk);
    while (!cmd_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_slot  = 4'(slot);
    cmd_pri   = 6'(pri);
    @(negedge aclk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    m_apply(op, slot, pri);
    chk("cmd_ready_drop", int'(cmd_ready), 0);
  endtask

  task automatic check_res(input string tag, input res_t e);
    chk({tag, "/hpri"}, int'(highpriority_out), e.hpri);
    chk({tag, "/hpritask"}, int'(ptr_hpritask_out), e.hp);
    chk({tag, "/nexttask"}, int'(ptr_nexttask_out), e.nx);
    chk({tag, "/any"}, int'(any_ready_out), e.any);
  endtask

  task automatic check_model(input string tag);
    check_res(tag, model_eval());
  endtask

  typedef struct {
    logic [1:0] op; int slot; int pri;
    int hpri; int hp; int nx; int any;
  } vec_t;
  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t  old;
    logic [1:0] rop;
    int    rslot, rpri;

    // Table runs before the first tick, so round-robin base stays 0.
    vecs[0]  = '{OP_READY,   3,  5,  5,  3,  3, 1};
    vecs[1]  = '{OP_BLOCK,   3,  0,  0,  0,  0, 0};
    vecs[2]  = '{OP_BLOCK,   3,  0,  0,  0,  0, 0};
    vecs[3]  = '{OP_READY,   2,  4,  4,  2,  2, 1};
    vecs[4]  = '{OP_READY,   7,  4,  4,  2,  2, 1};
    vecs[5]  = '{OP_READY,   9,  4,  4,  2,  2, 1};
    vecs[6]  = '{OP_READY,   5,  2,  4,  2,  2, 1};
    vecs[7]  = '{OP_SETPRI,  5,  6,  6,  5,  5, 1};
    vecs[8]  = '{OP_SETPRI, 11, 63,  6,  5,  5, 1};
    vecs[9]  = '{OP_READY,  11, 63, 63, 11, 11, 1};
    vecs[10] = '{OP_NOP,     0,  0, 63, 11, 11, 1};
    vecs[11] = '{OP_READY,  11,  0,  6,  5,  5, 1};
    vecs[12] = '{OP_BLOCK,   5,  0,  4,  2,  2, 1};
    vecs[13] = '{OP_READY,   0,  4,  4,  0,  2, 1};
    vecs[14] = '{OP_READY,  15,  4,  4,  0,  2, 1};

    m_reset();
    clk(2);
    chk("rst/cmd_ready", int'(cmd_ready), 1);
    chk("rst/tick_out", int'(tick_out), 0);
    check_res("rst", '{0, 0, 0, 0});
    #2 aresetn = 1'b1;
    tchk_en = 1'b1;

    // First-command latency: unchanged in PUBLISH, visible one edge later.
    send(OP_READY, 3, 5);
    clk(16);
    chk("latency/before_publish", int'(any_ready_out), 0);
    clk(1);
    check_res("latency", '{5, 3, 3, 1});

    foreach (vecs[k]) begin
      send(vecs[k].op, vecs[k].slot, vecs[k].pri);
      clk(19);
      check_res($sformatf("vec%0d", k), '{vecs[k].hpri, vecs[k].hp, vecs[k].nx, vecs[k].any});
      chk($sformatf("vec%0d/cmd_ready", k), int'(cmd_ready), 1);
    end

    // Reset in the middle of a scan clears outputs without a clock edge.
    send(OP_READY, 1, 9);
    clk(5);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst/cmd_ready", int'(cmd_ready), 1);
    chk("midrst/tick_out", int'(tick_out), 0);
    check_res("midrst", '{0, 0, 0, 0});
    @(negedge aclk);
    #2 aresetn = 1'b1;
    m_reset();
    send(OP_NOP, 0, 0);
    clk(19);
    check_res("post_rst_empty", '{0, 0, 0, 0});

    // Round-robin rotation across ticks.
    send(OP_READY, 2, 4);
    send(OP_READY, 7, 4);
    send(OP_READY, 9, 4);
    send(OP_READY, 5, 2);
    clk(19);
    check_res("rr_setup", '{4, 2, 2, 1});
    wait_phase(20); m_tick(); check_res("rr_tick1", '{4, 2, 7, 1});
    wait_phase(20); m_tick(); check_res("rr_tick2", '{4, 2, 9, 1});
    wait_phase(20); m_tick(); check_res("rr_tick3", '{4, 2, 2, 1});
    wait_phase(20); m_tick(); check_res("rr_tick4", '{4, 2, 7, 1});

    send(OP_BLOCK, 2, 0);
    send(OP_BLOCK, 7, 0);
    send(OP_BLOCK, 9, 0);
    send(OP_BLOCK, 5, 0);
    clk(19);
    check_res("block_all", '{0, 0, 0, 0});

    send(OP_READY, 4, 3);
    send(OP_READY, 12, 3);
    clk(19);
    check_model("tie_setup");

    // Command accepted on the very edge that samples tick_out.
    wait_phase(TD - 1);
    chk("cmdtick/ready_before", int'(cmd_ready), 1);
    chk("cmdtick/tick_seen", int'(tick_out), 1);
    old = model_eval();
    cmd_valid = 1'b1; cmd_op = OP_READY; cmd_slot = 4'd8; cmd_pri = 6'd3;
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    m_apply(OP_READY, 8, 3);
    m_rr = old.nx;
    chk("cmdtick/ready_p0", int'(cmd_ready), 0);
    wait_phase(10); chk("cmdtick/ready_p10", int'(cmd_ready), 0);
    wait_phase(17); chk("cmdtick/ready_p17", int'(cmd_ready), 1);
    wait_phase(20); chk("cmdtick/ready_p20", int'(cmd_ready), 0);
    wait_phase(36); chk("cmdtick/ready_p36", int'(cmd_ready), 1);
    wait_phase(40); chk("cmdtick/ready_p40", int'(cmd_ready), 1);
    check_model("cmdtick");

    // Tick arriving while a command scan is in flight.
    wait_phase(TD - 6);
    old = model_eval();
    cmd_valid = 1'b1; cmd_op = OP_BLOCK; cmd_slot = 4'd8; cmd_pri = 6'd0;
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    m_apply(OP_BLOCK, 8, 0);
    m_rr = old.nx;
    wait_phase(12); chk("scantick/ready_p12", int'(cmd_ready), 1);
    wait_phase(20); chk("scantick/ready_p20", int'(cmd_ready), 0);
    wait_phase(31); chk("scantick/ready_p31", int'(cmd_ready), 1);
    wait_phase(40);
    check_model("scantick");

    // Randomized commands with ties, one tick per window.
    for (int w = 0; w < 10; w++) begin
      wait_phase(20);
      m_tick();
      check_model($sformatf("rnd%0d/tick", w));
      for (int c = 0; c < 3; c++) begin
        rop   = 2'($urandom_range(0, 3));
        rslot = int'($urandom_range(0, NS - 1));
        rpri  = int'($urandom_range(0, 3));
        send(rop, rslot, rpri);
        clk(19);
        check_model($sformatf("rnd%0d/cmd%0d", w, c));
      end
    end

    tchk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
